// File: rtl/fetch_pkg.sv
// Shared rv32i front-end types: widths, reset PC, decoder opcodes and the fetch buffer entry.
// FETCH_MISALIGN_EN adds a per-entry misalign tag; no latency or backpressure of its own.
package fetch_pkg;

  localparam int INSTR_W  = 32;
  localparam int PC_W     = 32;
  localparam int OPCODE_W = 7;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [PC_W-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  localparam logic [OPCODE_W-1:0] I_TYPE = 7'b0010011;
  localparam logic [OPCODE_W-1:0] R_TYPE = 7'b0110011;
  localparam logic [OPCODE_W-1:0] LW     = 7'b0000011;
  localparam logic [OPCODE_W-1:0] SW     = 7'b0100011;
  localparam logic [OPCODE_W-1:0] BR     = 7'b1100011;
  localparam logic [OPCODE_W-1:0] JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] JALR   = 7'b1100111;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
`ifdef FETCH_MISALIGN_EN
    logic               misalign;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// 2-entry fetch buffer; write visible at head the cycle after push, flush beats push/pop.
// No internal backpressure: the caller never pushes into a full buffer unless it also pops.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok, push_ok;

  assign pop_ok  = pop && (count_q != 2'd0);
  assign push_ok = push && ((count_q != 2'd2) || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_d = ~rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  // An empty buffer presents zeros so stale words never leak onto the decode bus.
  assign head  = (count_q == 2'd0) ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// rv32i fetch: request->if_valid 2 cycles, 1 instr/cycle; if_ready low holds head and stops requests at 2 outstanding.
// Redirect flushes buffered/in-flight words; FETCH_MISALIGN_EN adds if_misalign for unaligned redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [PC_W-1:0]     if_pc,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [OPCODE_W-1:0] if_opcode
`ifdef FETCH_MISALIGN_EN
  ,
  output logic                if_misalign
`endif
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            drop_q, drop_d;
  logic [1:0]      count;
  logic [2:0]      occupancy;
  logic            push, pop;
  fetch_entry_t    push_dat, head;
`ifdef FETCH_MISALIGN_EN
  logic            pc_mis_q, pc_mis_d;
  logic            req_mis_q, req_mis_d;
`endif

  assign pop  = if_valid && if_ready;
  assign push = inflight_q && !drop_q;

  // Buffered plus in-flight words after this cycle's pop; a request only issues if its word has a slot.
  assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign imem_req  = !reset && !redirect_valid && (occupancy < 3'(DEPTH));
  assign imem_addr = pc_q;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    drop_d     = redirect_valid && inflight_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & PC_ALIGN_MASK;
    end else if (imem_req) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end
  end

`ifdef FETCH_MISALIGN_EN
  always_comb begin
    pc_mis_d  = pc_mis_q;
    req_mis_d = req_mis_q;
    if (redirect_valid) begin
      pc_mis_d = (redirect_pc[1:0] != 2'b00);
    end else if (imem_req) begin
      pc_mis_d  = 1'b0;
      req_mis_d = pc_mis_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_mis_q  <= 1'b0;
      req_mis_q <= 1'b0;
    end else begin
      pc_mis_q  <= pc_mis_d;
      req_mis_q <= req_mis_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    push_dat       = '0;
    push_dat.pc    = req_pc_q;
    push_dat.instr = imem_rdata;
`ifdef FETCH_MISALIGN_EN
    push_dat.misalign = req_mis_q;
`endif
  end

  fetch_fifo u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .count    (count),
    .head     (head)
  );

  assign if_valid  = !reset && (count != 2'd0);
  assign if_pc     = reset ? '0 : head.pc;
  assign if_instr  = reset ? '0 : head.instr;
  assign if_opcode = if_instr[OPCODE_W-1:0];
`ifdef FETCH_MISALIGN_EN
  assign if_misalign = !reset && head.misalign;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written stall/stream and misalign sequences.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;
`ifdef FETCH_MISALIGN_EN
  logic        if_misalign;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_opcode      (if_opcode)
`ifdef FETCH_MISALIGN_EN
    ,
    .if_misalign    (if_misalign)
`endif
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    logic [6:0] op;
    case (a[4:2])
      3'd0:    op = I_TYPE;
      3'd1:    op = R_TYPE;
      3'd2:    op = LW;
      3'd3:    op = SW;
      3'd4:    op = BR;
      3'd5:    op = JAL;
      3'd6:    op = JALR;
      default: op = I_TYPE;
    endcase
    return {a[26:2], op};
  endfunction

  // Synchronous memory model: word for the requested address one cycle later, junk otherwise.
  always @(posedge clk) imem_rdata <= imem_req ? instr_of(imem_addr) : 32'hDEAD_BEEF;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic void add(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy,
                              input logic ereq, input logic [31:0] eaddr, input logic evld, input logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ereq = ereq; v.eaddr = eaddr; v.evld = evld; v.epc = epc;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  logic [31:0] exp_pc;
  logic [31:0] hold_pc;
  logic [31:0] exp_instr;
  logic        stalled;
  int          n;

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Streaming with if_ready=1
    add(1,0,0,1, 0,32'h0,0,0);
    add(0,0,0,1, 1,32'h0,0,0);
    add(0,0,0,1, 1,32'h4,0,0);
    add(0,0,0,1, 1,32'h8,1,32'h0);
    add(0,0,0,1, 1,32'hC,1,32'h4);
    add(0,0,0,1, 1,32'h10,1,32'h8);
    // Stall from cycle 0, release at cycle 5
    add(1,0,0,0, 0,32'h14,0,0);
    add(0,0,0,0, 1,32'h0,0,0);
    add(0,0,0,0, 1,32'h4,0,0);
    add(0,0,0,0, 0,32'h8,1,32'h0);
    add(0,0,0,0, 0,32'h8,1,32'h0);
    add(0,0,0,0, 0,32'h8,1,32'h0);
    add(0,0,0,1, 1,32'h8,1,32'h0);
    add(0,0,0,1, 1,32'hC,1,32'h4);
    add(0,0,0,1, 1,32'h10,1,32'h8);
    // Redirect with buffer occupied and a fetch in flight
    add(1,0,0,0, 0,32'h14,0,0);
    add(0,0,0,0, 1,32'h0,0,0);
    add(0,0,0,0, 1,32'h4,0,0);
    add(0,1,32'h100,0, 0,32'h8,1,32'h0);
    add(0,0,0,1, 1,32'h100,0,0);
    add(0,0,0,1, 1,32'h104,0,0);
    add(0,0,0,1, 1,32'h108,1,32'h100);
    add(0,0,0,1, 1,32'h10C,1,32'h104);
    // Redirect coinciding with push and pop
    add(1,0,0,1, 0,32'h110,0,0);
    add(0,0,0,1, 1,32'h0,0,0);
    add(0,0,0,1, 1,32'h4,0,0);
    add(0,0,0,1, 1,32'h8,1,32'h0);
    add(0,1,32'h200,1, 0,32'hC,1,32'h4);
    add(0,0,0,1, 1,32'h200,0,0);
    add(0,0,0,1, 1,32'h204,0,0);
    add(0,0,0,1, 1,32'h208,1,32'h200);
    // Back-to-back redirects, last one unaligned
    add(1,0,0,1, 0,32'h20C,0,0);
    add(0,0,0,1, 1,32'h0,0,0);
    add(0,0,0,1, 1,32'h4,0,0);
    add(0,0,0,1, 1,32'h8,1,32'h0);
    add(0,1,32'h200,1, 0,32'hC,1,32'h4);
    add(0,1,32'h102,1, 0,32'h200,0,0);
    add(0,0,0,1, 1,32'h100,0,0);
    add(0,0,0,1, 1,32'h104,0,0);
    add(0,0,0,1, 1,32'h108,1,32'h100);
    // One-cycle reset mid-stream with a request in flight
    add(1,0,0,1, 0,32'h10C,0,0);
    add(0,0,0,1, 1,32'h0,0,0);
    add(0,0,0,1, 1,32'h4,0,0);
    add(0,0,0,1, 1,32'h8,1,32'h0);
    add(0,0,0,1, 1,32'hC,1,32'h4);
    add(1,0,0,1, 0,32'h10,0,0);
    add(0,0,0,1, 1,32'h0,0,0);
    add(0,0,0,1, 1,32'h4,0,0);
    add(0,0,0,1, 1,32'h8,1,32'h0);

    foreach (tbl[i]) begin
      reset          = tbl[i].rst;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      if_ready       = tbl[i].rdy;
      #1;
      exp_instr = tbl[i].evld ? instr_of(tbl[i].epc) : 32'h0;
      chk($sformatf("row%0d imem_req", i), imem_req, tbl[i].ereq);
      chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].eaddr);
      chk($sformatf("row%0d if_valid", i), if_valid, tbl[i].evld);
      chk($sformatf("row%0d if_pc", i), if_pc, tbl[i].epc);
      chk($sformatf("row%0d if_instr", i), if_instr, exp_instr);
      chk($sformatf("row%0d if_opcode", i), if_opcode, exp_instr[6:0]);
      @(negedge clk);
    end

    // Periodic backpressure: in-order delivery, no gaps, head stable while stalled
    reset = 1'b1; redirect_valid = 1'b0; if_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_pc = 32'h0; stalled = 1'b0; hold_pc = '0;
    for (int i = 0; i < 60; i++) begin
      if_ready = ((i % 3) != 2);
      #1;
      if (stalled) begin
        chk("stall hold valid", if_valid, 1);
        chk("stall hold pc", if_pc, hold_pc);
      end
      if (if_valid && if_ready) begin
        chk("stream pc", if_pc, exp_pc);
        chk("stream instr", if_instr, instr_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      stalled = if_valid && !if_ready;
      hold_pc = if_pc;
      @(negedge clk);
    end
    chk("stream progress", (exp_pc >= 32'd100), 1);

`ifdef FETCH_MISALIGN_EN
    reset = 1'b1; if_ready = 1'b1;
    @(negedge clk);
    #1 chk("misalign reset", if_misalign, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1 chk("misalign addr", imem_addr, 32'h100);
    n = 0;
    while (!if_valid && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk("misalign wait", (n < 10), 1);
    chk("misalign pc", if_pc, 32'h100);
    chk("misalign tag", if_misalign, 1);
    @(negedge clk); #1;
    chk("misalign next pc", if_pc, 32'h104);
    chk("misalign next tag", if_misalign, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
